multicycle_control_fsm: RTL and testbench
=========================================

MULTICYCLE_CONTROL_FSM -- requirements
Module: multicycle_control_fsm

Interface
REQ-001 Parameter: none; all encodings SHALL be fixed localparams.
REQ-002 clk  input  1  single clock; all state changes SHALL occur on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 opcode  input  6  instruction opcode from the instruction register.
REQ-005 zero  input  1  ALU zero flag.
REQ-006 mem_ready  input  1  cache/memory access complete; a read result or write acknowledge is valid this cycle.
REQ-007 Outputs (Moore, decoded from state only, except where stated):
- pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write, mem_to_reg, reg_dest, reg_write, alu_src_a: output, 1 bit each.
- alu_src_b: output, 2 bits; 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = immediate<<2.
- alu_op: output, 2 bits; 00 = add, 01 = subtract, 10 = funct.
- pc_src: output, 2 bits; 00 = ALU, 01 = ALUOut, 10 = jump target.
- state: output, 4 bits; debug view of the current state.

Function
REQ-008 The block SHALL provide the following states: IDLE=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_RD=4, MEM_WB=5, MEM_WR=6, EXEC=7, ALU_WB=8, BRANCH=9, JUMP=10, ADDI_EX=11, ADDI_WB=12.
REQ-009 In IDLE, all outputs SHALL be 0; the next state SHALL be FETCH unconditionally.
REQ-010 FETCH SHALL assert mem_read, with i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00 and pc_src=00.
REQ-011 In FETCH, ir_write and pc_write SHALL equal mem_ready; FETCH SHALL hold while mem_ready=0 and SHALL go to DECODE when mem_ready=1.
REQ-012 DECODE SHALL drive alu_src_a=0, alu_src_b=11 and alu_op=00, then branch on opcode:
- 000000 goes to EXEC.
- 100011 and 101011 go to MEM_ADDR.
- 000100 goes to BRANCH.
- 001000 goes to ADDI_EX.
- 000010 goes to JUMP.
- Any other opcode goes to FETCH, with no register or memory write.
REQ-013 MEM_ADDR SHALL drive alu_src_a=1, alu_src_b=10 and alu_op=00; it SHALL go to MEM_RD for opcode 100011 and to MEM_WR otherwise.
REQ-014 MEM_RD SHALL drive mem_read=1 and i_or_d=1; it SHALL hold until mem_ready=1, then go to MEM_WB.
REQ-015 MEM_WR SHALL drive mem_write=1 and i_or_d=1; it SHALL hold until mem_ready=1, then go to FETCH.
REQ-016 MEM_WB SHALL drive reg_write=1, mem_to_reg=1 and reg_dest=0, then go to FETCH.
REQ-017 EXEC SHALL drive alu_src_a=1, alu_src_b=00 and alu_op=10, then go to ALU_WB.
REQ-018 ALU_WB SHALL drive reg_write=1, reg_dest=1 and mem_to_reg=0, then go to FETCH.
REQ-019 ADDI_EX SHALL drive alu_src_a=1, alu_src_b=10 and alu_op=00, then go to ADDI_WB.
REQ-020 ADDI_WB SHALL drive reg_write=1 and reg_dest=0, then go to FETCH.
REQ-021 BRANCH SHALL drive alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1 and pc_src=01, then go to FETCH.
REQ-022 JUMP SHALL drive pc_write=1 and pc_src=10, then go to FETCH.
REQ-023 mem_read and mem_write SHALL never be asserted in the same cycle.
REQ-024 reg_write SHALL be asserted for exactly one cycle per writing instruction.
REQ-025 Latency in cycles, counted from FETCH entry with mem_ready=1 in every memory state:
- R-type: 4.
- lw: 5.
- sw: 4.
- beq: 3.
- j: 3.
- addi: 4.
REQ-026 Each cycle with mem_ready=0 in FETCH, MEM_RD or MEM_WR SHALL add exactly one cycle.
REQ-027 Any unused state encoding (13-15) SHALL go to IDLE on the next clock.

Reset
REQ-028 While rst_n=0, the state SHALL be IDLE and all outputs SHALL be 0, regardless of clk.
REQ-029 Reset asserted mid-instruction, including during a stalled MEM_WR, SHALL abort immediately; no write strobe SHALL remain asserted.
REQ-030 After rst_n deasserts, the first rising edge SHALL enter FETCH.

Configuration
REQ-031 Macro BNE_SUPPORT_EN: when defined, opcode 000101 in DECODE SHALL go to a BNE state (encoding 13).
- The BNE state SHALL be identical to BRANCH, except that pc_write_cond is driven as a condition on zero=0.
- To achieve this, the BNE state SHALL assert an added 1-bit output branch_ne.
REQ-032 When BNE_SUPPORT_EN is not defined, branch_ne SHALL be absent, opcode 000101 SHALL be treated as illegal, and encoding 13 SHALL be unused.

Verification
REQ-033 Reset: rst_n low for 3 cycles, then high -> all outputs 0 and state=0 while low; state=1 one edge after release.
REQ-034 add with mem_ready=1 always -> states 1,2,7,8,1; reg_write=1 and reg_dest=1 only in state 8.
REQ-035 lw with mem_ready low for 2 cycles in MEM_RD -> states 1,2,3,4,4,4,5,1; mem_read=1 and i_or_d=1 for all 3 MEM_RD cycles.
REQ-036 sw, with rst_n pulsed low during a stalled MEM_WR -> mem_write drops to 0 asynchronously; the next instruction restarts from IDLE then FETCH.
REQ-037 Opcode 111111 -> states 1,2,1, with reg_write=0 and mem_write=0 throughout.
REQ-038 beq and j -> 3-cycle paths.
- beq: pc_write_cond=1, alu_op=01, pc_src=01 in state 9.
- j: pc_write=1, pc_src=10 in state 10.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// Multicycle processor control unit: Moore FSM that sequences fetch, decode,
// execute, memory access and write-back for R-type, lw, sw, beq, j and addi.
// Memory states stall on mem_ready. Optional build macro BNE_SUPPORT_EN adds a
// BNE state (encoding 13) and a branch_ne output that tells the datapath to
// qualify pc_write_cond with zero=0 instead of zero=1.
//
// Handshake: mem_read/mem_write are held high while the FSM waits in FETCH,
// MEM_RD or MEM_WR; the access completes in the cycle mem_ready=1, and the FSM
// leaves the state on that clock edge. No other handshake exists.
module multicycle_control_fsm (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       ir_write,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       mem_to_reg,
    output logic       reg_dest,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src,
`ifdef BNE_SUPPORT_EN
    output logic       branch_ne,
`endif
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        FETCH    = 4'd1,
        DECODE   = 4'd2,
        MEM_ADDR = 4'd3,
        MEM_RD   = 4'd4,
        MEM_WB   = 4'd5,
        MEM_WR   = 4'd6,
        EXEC     = 4'd7,
        ALU_WB   = 4'd8,
        BRANCH   = 4'd9,
        JUMP     = 4'd10,
        ADDI_EX  = 4'd11,
        ADDI_WB  = 4'd12
`ifdef BNE_SUPPORT_EN
        ,
        BNE      = 4'd13
`endif
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef BNE_SUPPORT_EN
    localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

    localparam logic [1:0] SRC_B_REG   = 2'b00;
    localparam logic [1:0] SRC_B_FOUR  = 2'b01;
    localparam logic [1:0] SRC_B_IMM   = 2'b10;
    localparam logic [1:0] SRC_B_IMMSH = 2'b11;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    state_t state_q;
    state_t state_d;

    // State register; async reset forces IDLE so all decoded outputs drop at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

    // Next-state logic; unused encodings fall back to IDLE.
    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE:     state_d = FETCH;
            FETCH:    state_d = mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (opcode)
                    OP_RTYPE:     state_d = EXEC;
                    OP_LW, OP_SW: state_d = MEM_ADDR;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDI_EX;
                    OP_J:         state_d = JUMP;
`ifdef BNE_SUPPORT_EN
                    OP_BNE:       state_d = BNE;
`endif
                    default:      state_d = FETCH;
                endcase
            end
            MEM_ADDR: state_d = (opcode == OP_LW) ? MEM_RD : MEM_WR;
            MEM_RD:   state_d = mem_ready ? MEM_WB : MEM_RD;
            MEM_WB:   state_d = FETCH;
            MEM_WR:   state_d = mem_ready ? FETCH : MEM_WR;
            EXEC:     state_d = ALU_WB;
            ALU_WB:   state_d = FETCH;
            BRANCH:   state_d = FETCH;
            JUMP:     state_d = FETCH;
            ADDI_EX:  state_d = ADDI_WB;
            ADDI_WB:  state_d = FETCH;
`ifdef BNE_SUPPORT_EN
            BNE:      state_d = FETCH;
`endif
            default:  state_d = IDLE;
        endcase
    end

    // Output decode from state; only FETCH's ir_write/pc_write look at mem_ready.
    // zero is consumed by the datapath's branch gating, not here.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        ir_write      = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dest      = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRC_B_REG;
        alu_op        = ALU_ADD;
        pc_src        = PC_ALU;
`ifdef BNE_SUPPORT_EN
        branch_ne     = 1'b0;
`endif
        case (state_q)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRC_B_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            DECODE: begin
                alu_src_b = SRC_B_IMMSH;
            end
            MEM_ADDR, ADDI_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRC_B_IMM;
            end
            MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
            end
            ALU_WB: begin
                reg_write = 1'b1;
                reg_dest  = 1'b1;
            end
            ADDI_WB: begin
                reg_write = 1'b1;
            end
            BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_src        = PC_ALUOUT;
            end
`ifdef BNE_SUPPORT_EN
            BNE: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_src        = PC_ALUOUT;
                branch_ne     = 1'b1;
            end
`endif
            JUMP: begin
                pc_write = 1'b1;
                pc_src   = PC_JUMP;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: a per-cycle vector table of inputs with
// expected state and packed outputs, plus a hand-written async-reset sequence
// during a stalled store.
module tb_multicycle_control_fsm;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write;
    logic       mem_to_reg, reg_dest, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_src;
    logic [3:0] state;
`ifdef BNE_SUPPORT_EN
    logic       branch_ne;
`endif

    // Clock: 10 time-unit period, rising edges at 5, 15, ...
    always #5 clk = ~clk;

    multicycle_control_fsm dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .ir_write(ir_write),
        .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
        .mem_to_reg(mem_to_reg), .reg_dest(reg_dest), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src),
`ifdef BNE_SUPPORT_EN
        .branch_ne(branch_ne),
`endif
        .state(state)
    );

    // Packed view: pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write,
    // mem_to_reg, reg_dest, reg_write, alu_src_a, alu_src_b, alu_op, pc_src
    logic [15:0] out_word;
    assign out_word = {pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write,
                       mem_to_reg, reg_dest, reg_write, alu_src_a, alu_src_b, alu_op, pc_src};

    localparam logic [15:0] O_IDLE    = 16'h0000;
    localparam logic [15:0] O_FETCH   = 16'hA810;
    localparam logic [15:0] O_FETCH_S = 16'h0810;
    localparam logic [15:0] O_DECODE  = 16'h0030;
    localparam logic [15:0] O_MADDR   = 16'h0060;
    localparam logic [15:0] O_MRD     = 16'h1800;
    localparam logic [15:0] O_MWB     = 16'h0280;
    localparam logic [15:0] O_MWR     = 16'h1400;
    localparam logic [15:0] O_EXEC    = 16'h0048;
    localparam logic [15:0] O_ALUWB   = 16'h0180;
    localparam logic [15:0] O_ADDIEX  = 16'h0060;
    localparam logic [15:0] O_ADDIWB  = 16'h0080;
    localparam logic [15:0] O_BRANCH  = 16'h4045;
    localparam logic [15:0] O_JUMP    = 16'h8002;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    typedef struct packed {
        logic        rst_n;
        logic [5:0]  opcode;
        logic        zero;
        logic        mem_ready;
        logic [3:0]  exp_state;
        logic [15:0] exp_out;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic push(input logic r, input logic [5:0] op, input logic z, input logic mr,
                        input logic [3:0] st, input logic [15:0] o);
        vec_t v;
        v.rst_n = r; v.opcode = op; v.zero = z; v.mem_ready = mr;
        v.exp_state = st; v.exp_out = o;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [15:0] act,
                       input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0d: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    initial begin
        // Reset held for 3 cycles, then first cycle out of reset still IDLE
        for (int i = 0; i < 3; i++) push(0, OP_R, 0, 1, 4'd0, O_IDLE);
        push(1, OP_R, 0, 1, 4'd0, O_IDLE);
        // add, no stalls: 1,2,7,8
        push(1, OP_R, 0, 1, 4'd1, O_FETCH);
        push(1, OP_R, 0, 1, 4'd2, O_DECODE);
        push(1, OP_R, 1, 1, 4'd7, O_EXEC);
        push(1, OP_R, 0, 1, 4'd8, O_ALUWB);
        // lw with 2 stall cycles in MEM_RD: 1,2,3,4,4,4,5
        push(1, OP_LW, 0, 1, 4'd1, O_FETCH);
        push(1, OP_LW, 0, 1, 4'd2, O_DECODE);
        push(1, OP_LW, 0, 1, 4'd3, O_MADDR);
        push(1, OP_LW, 0, 0, 4'd4, O_MRD);
        push(1, OP_LW, 0, 0, 4'd4, O_MRD);
        push(1, OP_LW, 0, 1, 4'd4, O_MRD);
        push(1, OP_LW, 0, 1, 4'd5, O_MWB);
        // illegal opcode with a fetch stall: 1,1,2 then back to FETCH
        push(1, OP_BAD, 0, 0, 4'd1, O_FETCH_S);
        push(1, OP_BAD, 0, 1, 4'd1, O_FETCH);
        push(1, OP_BAD, 0, 1, 4'd2, O_DECODE);
        // beq: 1,2,9
        push(1, OP_BEQ, 1, 1, 4'd1, O_FETCH);
        push(1, OP_BEQ, 1, 1, 4'd2, O_DECODE);
        push(1, OP_BEQ, 1, 1, 4'd9, O_BRANCH);
        // j: 1,2,10
        push(1, OP_J, 0, 1, 4'd1, O_FETCH);
        push(1, OP_J, 0, 1, 4'd2, O_DECODE);
        push(1, OP_J, 0, 1, 4'd10, O_JUMP);
        // addi: 1,2,11,12
        push(1, OP_ADDI, 0, 1, 4'd1, O_FETCH);
        push(1, OP_ADDI, 0, 1, 4'd2, O_DECODE);
        push(1, OP_ADDI, 0, 1, 4'd11, O_ADDIEX);
        push(1, OP_ADDI, 0, 1, 4'd12, O_ADDIWB);
        // sw with one MEM_WR stall: 1,2,3,6,6
        push(1, OP_SW, 0, 1, 4'd1, O_FETCH);
        push(1, OP_SW, 0, 1, 4'd2, O_DECODE);
        push(1, OP_SW, 0, 1, 4'd3, O_MADDR);
        push(1, OP_SW, 0, 0, 4'd6, O_MWR);
        push(1, OP_SW, 0, 1, 4'd6, O_MWR);
        // bne opcode: branch state when enabled, illegal otherwise
        push(1, OP_BNE, 0, 1, 4'd1, O_FETCH);
        push(1, OP_BNE, 0, 1, 4'd2, O_DECODE);
`ifdef BNE_SUPPORT_EN
        push(1, OP_BNE, 0, 1, 4'd13, O_BRANCH);
`endif
        push(1, OP_R, 0, 1, 4'd1, O_FETCH);

        // Apply each vector on the falling edge, check 1 unit later
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst_n     = vecs[i].rst_n;
            opcode    = vecs[i].opcode;
            zero      = vecs[i].zero;
            mem_ready = vecs[i].mem_ready;
            #1;
            chk("state", i, {12'd0, state}, {12'd0, vecs[i].exp_state});
            chk("outputs", i, out_word, vecs[i].exp_out);
            chk("rd_wr_excl", i, {15'd0, mem_read & mem_write}, 16'd0);
        end

        // Async reset in the middle of a stalled store
        @(negedge clk);
        rst_n = 1'b0; opcode = OP_SW; mem_ready = 1'b1;
        #1 chk("sw_rst_state", 100, {12'd0, state}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("sw_idle", 101, {12'd0, state}, 16'd0);
        @(negedge clk);
        #1 chk("sw_fetch", 102, {12'd0, state}, 16'd1);
        @(negedge clk);
        #1 chk("sw_decode", 103, {12'd0, state}, 16'd2);
        @(negedge clk);
        mem_ready = 1'b0;
        #1 chk("sw_maddr", 104, {12'd0, state}, 16'd3);
        @(negedge clk);
        #1 chk("sw_memwr", 105, {12'd0, state}, 16'd6);
        chk("sw_wr_on", 105, {15'd0, mem_write}, 16'd1);
        @(negedge clk);
        #1 chk("sw_stall", 106, {12'd0, state}, 16'd6);
        #1 rst_n = 1'b0;
        #1 chk("sw_abort_wr", 107, {15'd0, mem_write}, 16'd0);
        chk("sw_abort_state", 107, {12'd0, state}, 16'd0);
        chk("sw_abort_out", 107, out_word, O_IDLE);
        @(negedge clk);
        mem_ready = 1'b1; opcode = OP_R;
        #1 chk("rst_hold", 108, {12'd0, state}, 16'd0);
        rst_n = 1'b1;
        @(negedge clk);
        #1 chk("restart_fetch", 109, {12'd0, state}, 16'd1);
        chk("restart_out", 109, out_word, O_FETCH);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
